// File: rtl/m3ds_tsenc_pkg.sv
// Shared constants, header codes and FSM state type for the timestamp encoder.
package m3ds_tsenc_pkg;

    localparam int unsigned TS_W            = 48;
    localparam int unsigned GRP_W           = 7;
    localparam int unsigned FULL_BYTES      = 7;
    localparam int unsigned DELTA_MAX_BYTES = 5;
    localparam int unsigned DELTA_LIMIT_BIT = 35;

    localparam logic [1:0] HDR_FULL  = 2'b11;
    localparam logic [1:0] HDR_DELTA = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StPay
    } state_e;

    // Header byte: packet type in [7:6], overflow flag in [0].
    function automatic logic [7:0] hdr_byte(input logic is_full, input logic ovf);
        return {(is_full ? HDR_FULL : HDR_DELTA), 5'b00000, ovf};
    endfunction

endpackage

// File: rtl/m3ds_tsenc_len.sv
// Chooses full vs delta packet and the delta payload length in 7-bit groups.
module m3ds_tsenc_len
    import m3ds_tsenc_pkg::*;
(
    input  logic [TS_W-1:0] delta_i,
    input  logic            first_flag_i,
    input  logic            sync_due_i,
    output logic            is_full_o,
    output logic [2:0]      nbytes_o
);

    // Highest non-zero group below the delta limit sets the byte count; zero still sends one byte.
    always_comb begin
        nbytes_o = 3'd1;
        for (int g = 1; g < DELTA_MAX_BYTES; g++) begin
            if (delta_i[g*GRP_W +: GRP_W] != '0) begin
                nbytes_o = 3'(g + 1);
            end
        end
        is_full_o = first_flag_i | sync_due_i | (delta_i[TS_W-1:DELTA_LIMIT_BIT] != '0);
    end

endmodule

// File: rtl/m3ds_tsenc_48.sv
// Timestamp encoder: captures the 48-bit counter on request and emits a header
// byte plus LSB-first 7-bit-group payload (full value or delta vs last capture).
// Optional periodic full-value sync is enabled by defining M3DS_TSENC_SYNC_EN.
module m3ds_tsenc_48
    import m3ds_tsenc_pkg::*;
#(
    parameter int unsigned SYNC_PERIOD = 256
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [TS_W-1:0] tsvalueb_i,
    input  logic            tsreq_i,
    output logic            pkt_valid_o,
    output logic [7:0]      pkt_data_o,
    input  logic            pkt_ready_i,
    output logic            busy_o,
    output logic            ovf_o
);

    state_e            state_q;
    logic [TS_W-1:0]   last_q;
    logic [TS_W-1:0]   sr_q;
    logic [2:0]        rem_q;      // payload bytes not yet placed on the bus
    logic              first_q;
    logic              ovf_q;
    logic              valid_q;
    logic [7:0]        data_q;

    logic              hs;
    logic              last_hs;
    logic              cap;
    logic              drop;
    logic [TS_W-1:0]   delta;
    logic              is_full;
    logic [2:0]        nbytes;
    logic              sync_due;
    logic [7:0]        next_byte;

`ifdef M3DS_TSENC_SYNC_EN
    logic [15:0] sync_q;

    // Sync counter; the first capture after reset counts as capture 1 of the period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else if (cap) begin
            if (first_q) begin
                sync_q <= 16'd1;
            end else if (is_full) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_q + 16'd1;
            end
        end
    end

    assign sync_due = (sync_q == 16'(SYNC_PERIOD - 1));
`else
    assign sync_due = 1'b0;
`endif

    // Handshake, capture and drop decode; capture is allowed on the final payload handshake.
    always_comb begin
        hs        = valid_q & pkt_ready_i;
        last_hs   = (state_q == StPay) & hs & (rem_q == 3'd0);
        cap       = tsreq_i & ((state_q == StIdle) | last_hs);
        drop      = tsreq_i & ~cap & (state_q != StIdle);
        delta     = tsvalueb_i - last_q;
        next_byte = {(rem_q != 3'd1), sr_q[GRP_W-1:0]};
    end

    m3ds_tsenc_len u_len (
        .delta_i      (delta),
        .first_flag_i (first_q),
        .sync_due_i   (sync_due),
        .is_full_o    (is_full),
        .nbytes_o     (nbytes)
    );

    // Packet FSM with registered byte outputs; a capture overrides the state update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            last_q  <= '0;
            sr_q    <= '0;
            rem_q   <= '0;
            first_q <= 1'b1;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (drop) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                StIdle: ;
                StHdr: begin
                    if (hs) begin
                        data_q  <= next_byte;
                        sr_q    <= sr_q >> GRP_W;
                        rem_q   <= rem_q - 3'd1;
                        state_q <= StPay;
                    end
                end
                StPay: begin
                    if (hs) begin
                        if (rem_q == 3'd0) begin
                            valid_q <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            data_q <= next_byte;
                            sr_q   <= sr_q >> GRP_W;
                            rem_q  <= rem_q - 3'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (cap) begin
                last_q  <= tsvalueb_i;
                first_q <= 1'b0;
                ovf_q   <= 1'b0;
                data_q  <= hdr_byte(is_full, ovf_q);
                valid_q <= 1'b1;
                sr_q    <= is_full ? tsvalueb_i : delta;
                rem_q   <= is_full ? 3'(FULL_BYTES) : nbytes;
                state_q <= StHdr;
            end
        end
    end

    assign pkt_valid_o = valid_q;
    assign pkt_data_o  = data_q;
    assign busy_o      = (state_q != StIdle);
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_m3ds_tsenc_48.sv
// Directed self-checking bench for the timestamp encoder.
module tb_m3ds_tsenc_48;

    logic        clk = 1'b0;
    logic        resetn;
    logic [47:0] tsvalueb_i;
    logic        tsreq_i;
    logic        pkt_valid_o;
    logic [7:0]  pkt_data_o;
    logic        pkt_ready_i;
    logic        busy_o;
    logic        ovf_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] ev [0:7];

    always #5 clk = ~clk;

    m3ds_tsenc_48 #(.SYNC_PERIOD(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .tsvalueb_i  (tsvalueb_i),
        .tsreq_i     (tsreq_i),
        .pkt_valid_o (pkt_valid_o),
        .pkt_data_o  (pkt_data_o),
        .pkt_ready_i (pkt_ready_i),
        .busy_o      (busy_o),
        .ovf_o       (ovf_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic [47:0] ts);
        tsvalueb_i = ts;
        tsreq_i    = 1'b1;
        step();
        tsreq_i    = 1'b0;
    endtask

    // Accept one byte (bounded wait) and compare it.
    task automatic take(input string tag, input logic [7:0] exp);
        bit got = 1'b0;
        pkt_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (pkt_valid_o) begin
                got = 1'b1;
                chk(tag, {56'd0, pkt_data_o}, {56'd0, exp});
            end
            step();
            if (got) break;
        end
        if (!got) chk({tag, " timeout"}, {63'd0, pkt_valid_o}, 64'd1);
    endtask

    task automatic expect_pkt(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            take($sformatf("%s[%0d]", tag, k), ev[k]);
        end
    endtask

    initial begin
        bit exp_full;
        int n;

        resetn      = 1'b0;
        tsreq_i     = 1'b0;
        tsvalueb_i  = '0;
        pkt_ready_i = 1'b0;
        step();
        step();
        chk("rst_valid", {63'd0, pkt_valid_o}, 64'd0);
        chk("rst_data", {56'd0, pkt_data_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_ovf", {63'd0, ovf_o}, 64'd0);
        resetn = 1'b1;
        step();

        // First capture after reset is a full packet; header valid the next cycle.
        pkt_ready_i = 1'b1;
        capture(48'h000000001234);
        chk("hdr_latency", {63'd0, pkt_valid_o}, 64'd1);
        ev = '{8'hC0, 8'hB4, 8'hA4, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
        expect_pkt("full1", 8);
        chk("idle_after_full", {63'd0, busy_o}, 64'd0);

        // Delta of 0xCC.
        capture(48'h000000001300);
        ev = '{8'h80, 8'hCC, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_pkt("delta1", 3);

        // Backpressure mid-payload: byte must hold for 5 cycles.
        capture(48'h000000001400);
        chk("bp_hdr", {56'd0, pkt_data_o}, 64'h80);
        step();
        chk("bp_p0", {56'd0, pkt_data_o}, 64'h80);
        pkt_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", {63'd0, pkt_valid_o}, 64'd1);
            chk("bp_hold_data", {56'd0, pkt_data_o}, 64'h80);
        end
        pkt_ready_i = 1'b1;
        step();
        chk("bp_p1", {56'd0, pkt_data_o}, 64'h02);
        step();
        chk("bp_done_valid", {63'd0, pkt_valid_o}, 64'd0);
        chk("bp_done_busy", {63'd0, busy_o}, 64'd0);

        // Request while busy is dropped and flags overflow.
        pkt_ready_i = 1'b0;
        capture(48'h000000001500);
        chk("drop_ovf_pre", {63'd0, ovf_o}, 64'd0);
        capture(48'h000000001580);
        chk("drop_ovf_set", {63'd0, ovf_o}, 64'd1);
        chk("drop_hdr_hold", {56'd0, pkt_data_o}, 64'h80);
        ev = '{8'h80, 8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_pkt("drop_pkt", 3);
        chk("ovf_sticky", {63'd0, ovf_o}, 64'd1);
        capture(48'h000000001600);
        chk("ovf_clear", {63'd0, ovf_o}, 64'd0);
        ev = '{8'h81, 8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_pkt("ovf_pkt", 3);

        // Back-to-back capture on the last-byte handshake.
        capture(48'h000000001610);
        take("b2b_hdr", 8'h80);
        chk("b2b_last", {56'd0, pkt_data_o}, 64'h10);
        tsvalueb_i = 48'h000000001620;
        tsreq_i    = 1'b1;
        step();
        tsreq_i    = 1'b0;
        chk("b2b_valid", {63'd0, pkt_valid_o}, 64'd1);
        chk("b2b_hdr2", {56'd0, pkt_data_o}, 64'h80);
        chk("b2b_no_ovf", {63'd0, ovf_o}, 64'd0);
        ev = '{8'h80, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_pkt("b2b_pkt", 2);

        // Zero delta is the single byte 0x00.
        capture(48'h000000001620);
        ev = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_pkt("zero_delta", 2);

        // Reset mid-packet aborts output at once.
        pkt_ready_i = 1'b0;
        capture(48'h000000001700);
        step();
        resetn = 1'b0;
        #1;
        chk("abort_valid", {63'd0, pkt_valid_o}, 64'd0);
        chk("abort_busy", {63'd0, busy_o}, 64'd0);
        step();
        resetn = 1'b1;
        step();

        // Next capture after reset is full; all-ones value.
        capture(48'hFFFFFFFFFFFF);
        ev = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3F};
        expect_pkt("full_ones", 8);

        // Counter wrap gives a small delta.
        capture(48'h000000000002);
        ev = '{8'h80, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_pkt("wrap", 2);

        // Largest delta still sent as delta: 2^35-1 in 5 bytes.
        capture(48'h000800000001);
        ev = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h00, 8'h00};
        expect_pkt("delta_max", 6);

        // Delta of exactly 2^35 forces a full packet.
        capture(48'h001000000001);
        ev = '{8'hC0, 8'h81, 8'h80, 8'h80, 8'h80, 8'h80, 8'h82, 8'h00};
        expect_pkt("delta_limit", 8);

        // Eight small-delta captures from reset: header type and packet length.
        pkt_ready_i = 1'b0;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
        for (int k = 1; k <= 8; k++) begin
            pkt_ready_i = 1'b0;
            capture(48'(k * 16));
            exp_full = (k == 1);
`ifdef M3DS_TSENC_SYNC_EN
            exp_full = (k == 1) || (k == 4) || (k == 8);
`endif
            chk($sformatf("sync_hdr%0d", k), {56'd0, pkt_data_o},
                exp_full ? 64'hC0 : 64'h80);
            pkt_ready_i = 1'b1;
            n = 0;
            for (int i = 0; i < 20; i++) begin
                if (!busy_o) break;
                if (pkt_valid_o) n++;
                step();
            end
            chk($sformatf("sync_len%0d", k), 64'(n), exp_full ? 64'd8 : 64'd2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
